// File: rtl/mac_pkg.sv
// Shared types and constants for the signed multiply-accumulate slice.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned N     = 4;
  localparam int unsigned M     = 4;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned LEN   = 8;

  // Saturation rails for the default accumulator width
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Width needed to hold a term count in 0..len
  function automatic int unsigned cnt_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational saturating add of a sign-extended narrow operand into a wide one.
module sat_add_signed #(
  parameter int unsigned AW = 16,
  parameter int unsigned BW = 8
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          sat
);

  logic [AW:0] ext;

  // Exact sum in AW+1 bits; top two bits disagree exactly when it leaves the AW-bit range
  always_comb begin
    ext = {a[AW-1], a} + {{(AW+1-BW){b[BW-1]}}, b};
    sat = ext[AW] ^ ext[AW-1];
    sum = sat ? {ext[AW], {(AW-1){~ext[AW]}}} : ext[AW-1:0];
  end

endmodule

// File: rtl/signed_mac_accumulator.sv
// Accumulates signed products into a saturating sum and hands off one result per vector.
module signed_mac_accumulator #(
  parameter int unsigned N     = mac_pkg::N,
  parameter int unsigned M     = mac_pkg::M,
  parameter int unsigned ACC_W = mac_pkg::ACC_W,
  parameter int unsigned LEN   = mac_pkg::LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N+M-1:0]             prod,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           acc_out,
  output logic                       out_ovf,
  output logic [$clog2(LEN+1)-1:0]   out_count
);

  import mac_pkg::*;

  localparam int unsigned CW = cnt_w(LEN);

  state_t          state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CW-1:0]    count, count_n;
  logic             ovf, ovf_n;
  logic             load_out;
  logic             accept;
  logic [ACC_W-1:0] sum;
  logic             sat;

  sat_add_signed #(
    .AW (ACC_W),
    .BW (N + M)
  ) u_add (
    .a   (acc),
    .b   (prod),
    .sum (sum),
    .sat (sat)
  );

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // Next-state and next-accumulator logic
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    count_n  = count;
    ovf_n    = ovf;
    load_out = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_n   = sum;
          count_n = count + CW'(1);
          ovf_n   = ovf | sat;
          if ((count_n == CW'(LEN)) || in_last) begin
            state_n  = HOLD;
            load_out = 1'b1;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n = IDLE;
          acc_n   = '0;
          count_n = '0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      acc_out   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      count <= count_n;
      ovf   <= ovf_n;
      if (load_out) begin
        acc_out   <= acc_n;
        out_ovf   <= ovf_n;
        out_count <= count_n;
      end
    end
  end

endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Directed bench for signed_mac_accumulator: default instance plus an 8-bit-accumulator instance.
module tb_signed_mac_accumulator;

  logic clk = 1'b0;
  logic rst;

  // Default instance (ACC_W=16, LEN=8)
  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [7:0] prod;
  logic [15:0] acc_out;
  logic [3:0] out_count;

  // Narrow instance (ACC_W=8, LEN=8)
  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [7:0] b_prod;
  logic [7:0] b_acc_out;
  logic [3:0] b_out_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  signed_mac_accumulator #(.N(4), .M(4), .ACC_W(16), .LEN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  signed_mac_accumulator #(.N(4), .M(4), .ACC_W(8), .LEN(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .prod(b_prod),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready), .acc_out(b_acc_out),
    .out_ovf(b_out_ovf), .out_count(b_out_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic last);
    in_valid = 1'b1; prod = p; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p, input logic last);
    b_in_valid = 1'b1; b_prod = p; b_in_last = last;
    tick();
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0h want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0h want 1", in_ready); else passed++;
    total++; if (acc_out !== 16'h0000) $display("FAIL reset_acc_out: got %0h want 0", acc_out); else passed++;
    total++; if (out_count !== 4'd0) $display("FAIL reset_out_count: got %0d want 0", out_count); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %0h want 0", out_ovf); else passed++;
    total++; if (b_in_ready !== 1'b1) $display("FAIL reset_b_in_ready: got %0h want 1", b_in_ready); else passed++;
  endtask

  task automatic test_dot_product();
    out_ready = 1'b1;
    send(8'd3, 0); send(8'hFE, 0); send(8'd7, 0); send(8'hF8, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL dot_mid_valid: got %0h want 0", out_valid); else passed++;
    send(8'd1, 0); send(8'd0, 0); send(8'd5, 0); send(8'hFF, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL dot_out_valid: got %0h want 1", out_valid); else passed++;
    total++; if (acc_out !== 16'd5) $display("FAIL dot_acc_out: got %0h want 5", acc_out); else passed++;
    total++; if (out_count !== 4'd8) $display("FAIL dot_out_count: got %0d want 8", out_count); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL dot_out_ovf: got %0h want 0", out_ovf); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL dot_valid_drop: got %0h want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL dot_ready_back: got %0h want 1", in_ready); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_early_last();
    send(8'hFC, 0); send(8'hFC, 1);
    total++; if (out_valid !== 1'b1) $display("FAIL early_valid: got %0h want 1", out_valid); else passed++;
    total++; if (acc_out !== 16'hFFF8) $display("FAIL early_acc_out: got %0h want fff8", acc_out); else passed++;
    total++; if (out_count !== 4'd2) $display("FAIL early_count: got %0d want 2", out_count); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL early_ovf: got %0h want 0", out_ovf); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL early_in_ready: got %0h want 0", in_ready); else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL early_release: got %0h want 0", out_valid); else passed++;
  endtask

  task automatic test_pos_saturation();
    b_out_ready = 1'b0;
    send_b(8'd49, 0); send_b(8'd49, 0); send_b(8'd49, 1);
    total++; if (b_out_valid !== 1'b1) $display("FAIL psat_valid: got %0h want 1", b_out_valid); else passed++;
    total++; if (b_acc_out !== 8'h7F) $display("FAIL psat_acc_out: got %0h want 7f", b_acc_out); else passed++;
    total++; if (b_out_ovf !== 1'b1) $display("FAIL psat_ovf: got %0h want 1", b_out_ovf); else passed++;
    total++; if (b_out_count !== 4'd3) $display("FAIL psat_count: got %0d want 3", b_out_count); else passed++;
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
  endtask

  task automatic test_neg_saturation();
    send_b(8'hC8, 0); send_b(8'hC8, 0); send_b(8'hC8, 0); send_b(8'd49, 1);
    total++; if (b_acc_out !== 8'hB1) $display("FAIL nsat_acc_out: got %0h want b1", b_acc_out); else passed++;
    total++; if (b_out_ovf !== 1'b1) $display("FAIL nsat_ovf: got %0h want 1", b_out_ovf); else passed++;
    total++; if (b_out_count !== 4'd4) $display("FAIL nsat_count: got %0d want 4", b_out_count); else passed++;
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
    // A fresh vector must not inherit the previous vector's overflow flag
    send_b(8'd1, 1);
    total++; if (b_out_ovf !== 1'b0) $display("FAIL nsat_ovf_clear: got %0h want 0", b_out_ovf); else passed++;
    total++; if (b_acc_out !== 8'h01) $display("FAIL nsat_next_acc: got %0h want 1", b_acc_out); else passed++;
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    send(8'd2, 0); send(8'd3, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; prod = 8'd7;
      tick();
      total++; if (out_valid !== 1'b1 || acc_out !== 16'd5 || out_count !== 4'd2 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got v=%0h acc=%0h cnt=%0d rdy=%0h want v=1 acc=5 cnt=2 rdy=0",
                 i, out_valid, acc_out, out_count, in_ready);
      else passed++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %0h want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %0h want 1", in_ready); else passed++;
    send(8'd1, 1);
    total++; if (acc_out !== 16'd1 || out_count !== 4'd1) $display("FAIL bp_next_vector: got acc=%0h cnt=%0d want acc=1 cnt=1", acc_out, out_count); else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_vector();
    send(8'd5, 0); send(8'd5, 0); send(8'd5, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_hs: got v=%0h rdy=%0h want v=0 rdy=1", out_valid, in_ready); else passed++;
    total++; if (acc_out !== 16'd0 || out_count !== 4'd0 || out_ovf !== 1'b0) $display("FAIL rstmid_outs: got acc=%0h cnt=%0d ovf=%0h want 0 0 0", acc_out, out_count, out_ovf); else passed++;
    for (int i = 0; i < 8; i++) send(8'd1, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL rstmid_valid: got %0h want 1", out_valid); else passed++;
    total++; if (acc_out !== 16'd8) $display("FAIL rstmid_acc_out: got %0h want 8", acc_out); else passed++;
    total++; if (out_count !== 4'd8) $display("FAIL rstmid_count: got %0d want 8", out_count); else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; prod = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_prod = '0; b_out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_dot_product();
    test_early_last();
    test_pos_saturation();
    test_neg_saturation();
    test_backpressure();
    test_reset_mid_vector();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/signed_mac_accumulator.md
Name: signed_mac_accumulator

Overview:
- Sequential stage directly downstream of the combinational signed N x M multiplier.
- Consumes one signed product per valid/ready handshake and sign-extends it into a saturating ACC_W-bit accumulator.
- Emits the accumulated dot-product result after LEN products, or earlier on in_last, then clears for the next vector.
- Output is held under a valid/ready handshake until the consumer accepts it.

Parameters:
N, 4, multiplicand width feeding the upstream multiplier
M, 4, multiplier width feeding the upstream multiplier
ACC_W, 16, accumulator/result width (must be >= N+M)
LEN, 8, products per dot product (>= 1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  prod is valid this cycle
in_ready  output  1  block can accept prod this cycle
prod  input  N+M  two's-complement product from multiplier
in_last  input  1  qualifies prod as final term of the vector (early terminate)
out_valid  output  1  acc_out/out_ovf/out_count are valid
out_ready  input  1  consumer accepts result
acc_out  output  ACC_W  signed accumulated sum (saturated)
out_ovf  output  1  sticky: saturation occurred within this vector
out_count  output  $clog2(LEN+1)  number of products accumulated

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-vector or while holding a result): state=IDLE, acc=0, count=0, ovf=0, out_valid=0, acc_out=0, out_ovf=0, out_count=0. in_ready=1 the first cycle after reset.
- FSM states:
  - IDLE: no terms accumulated.
  - ACCUM: at least 1 and fewer than LEN terms accumulated.
  - HOLD: result presented on the outputs.
- in_ready = (state != HOLD), combinational from state only.
- Accept = in_valid & in_ready.
- On accept: acc <= sat(acc + sext(prod)); count <= count+1; ovf <= ovf | saturated this add.
- sext: prod is signed N+M bits, sign-extended to ACC_W+1 bits for the add.
- Saturation: if the exact sum > 2^(ACC_W-1)-1, clamp to that value. If it is < -2^(ACC_W-1), clamp to -2^(ACC_W-1). Either case sets ovf.
- Once saturated, later terms keep adding to the clamped value; there is no latching at the rail.
- Transitions:
  - IDLE -> ACCUM on accept when count+1 < LEN and in_last=0.
  - IDLE/ACCUM -> HOLD on accept when count+1 == LEN or in_last=1.
  - ACCUM stays in ACCUM otherwise; no accept leaves the state unchanged.
  - HOLD -> IDLE on out_valid & out_ready. On that edge, acc/count/ovf clear to 0.
- Latency: the final term is accepted at edge t. out_valid=1 and acc_out/out_ovf/out_count are registered and stable from edge t until the handshake.
- Back-to-back throughput: 1 product/cycle inside a vector. The cycle in which the result is taken has in_ready=0, so a new vector starts in the cycle after out_ready is seen. Minimum gap is 1 bubble per vector.
- in_last with LEN=1, or in_last on the first term: go directly IDLE -> HOLD with out_count=1.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0: prod is not consumed. Upstream holds prod.
- No X propagation: unaccepted prod never affects state.

Decomposition:
- Shared package mac_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - Default width constants N, M, ACC_W, LEN.
  - Localparams ACC_MAX and ACC_MIN, plus the count width function.
- One natural sub-module: sat_add_signed (combinational). Inputs a[ACC_W] and b[N+M]; outputs sum[ACC_W] and sat flag. It is reusable by other accumulating stages.
- The FSM and registers stay in signed_mac_accumulator.

Test Plan:
- Basic dot product, defaults: prods 3,-2,7,-8,1,0,5,-1 on consecutive cycles with out_ready=1 -> out_valid 1 cycle after the 8th accept; acc_out=5, out_count=8, out_ovf=0.
- Early last: prods -4,-4 with in_last on the second -> acc_out=-8 (0xFFF8), out_count=2, out_ovf=0; in_ready=0 during HOLD.
- Positive saturation, ACC_W=8: prods 49,49,49 (7*7) -> acc 49, 98, then clamps to 127 on the third term; out_ovf=1, out_count=3 on in_last.
- Negative saturation and recovery, ACC_W=8: prods -56,-56,-56,49 with last -> sequence clamps to -128 on the third term, then 49 gives acc_out=-79, out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses ignored; raising out_ready -> out_valid drops the next cycle and the next vector's first term is accepted the following cycle.
- Reset mid-vector: 3 terms accepted, rst pulsed 1 cycle -> all outputs 0, state IDLE. A fresh 8-term vector of all 1s then gives acc_out=8.
